// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in over valid/ready, one bit per clock out.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   GAP       = 0,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt_reg;
    logic [GW-1:0]    gap_cnt_reg;
    logic [WIDTH-1:0] ordered;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             parity_reg;
`endif

    // Reorder the word so the first bit to send always sits in the top position.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            assign ordered[gi] = (MSB_FIRST != 0) ? in_data[gi] : in_data[WIDTH-1-gi];
        end
    endgenerate

    always_comb begin
        in_ready = 1'b0;
        if (reset_n) begin
            case (state_reg)
                S_IDLE:  in_ready = 1'b1;
                S_SHIFT: in_ready = (GAP == 0) && (bit_cnt_reg == LAST_BIT);
                S_GAP:   in_ready = (gap_cnt_reg == LAST_GAP);
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            dout        <= IDLE_BIT;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
`ifdef SER_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else if (accept) begin
            // First bit goes straight to dout; the rest wait in the shift register.
            state_reg   <= S_SHIFT;
            dout        <= ordered[WIDTH-1];
            shift_reg   <= {ordered[WIDTH-2:0], 1'b0};
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            dout_valid  <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
`ifdef SER_PARITY_EN
            parity_reg  <= ^in_data;
`endif
        end else begin
            case (state_reg)
                S_SHIFT: begin
                    frame_start <= 1'b0;
                    if (bit_cnt_reg == LAST_BIT) begin
                        dout       <= IDLE_BIT;
                        dout_valid <= 1'b0;
                        if (GAP > 0) begin
                            state_reg   <= S_GAP;
                            gap_cnt_reg <= '0;
                            busy        <= 1'b1;
                        end else begin
                            state_reg <= S_IDLE;
                            busy      <= 1'b0;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
`ifdef SER_PARITY_EN
                        if (bit_cnt_reg == CW'(WIDTH - 1)) begin
                            dout <= parity_reg;
                        end else begin
                            dout      <= shift_reg[WIDTH-1];
                            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                        end
`else
                        dout      <= shift_reg[WIDTH-1];
                        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
`endif
                    end
                end
                S_GAP: begin
                    if (gap_cnt_reg == LAST_GAP) begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
                default: begin
                    state_reg   <= S_IDLE;
                    dout        <= IDLE_BIT;
                    dout_valid  <= 1'b0;
                    frame_start <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
